// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin arbiter with packet locking. A granted port keeps the channel
// until its last beat transfers, and it may win up to `weight` packets in a row.
module wrr_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int WEIGHT_W   = 4,
  parameter int PORT_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          last,
  input  logic [NUM_PORTS*WEIGHT_W-1:0] weight,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          grant,
  output logic [PORT_WIDTH-1:0]         grant_id,
  output logic                          grant_valid
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state_reg, state_next;
  logic [PORT_WIDTH-1:0] ptr_reg, ptr_next;
  logic [PORT_WIDTH-1:0] grant_id_reg, grant_id_next;
  logic [WEIGHT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_PORTS-1:0]  grant_reg, grant_next;

  logic                  found;
  logic [PORT_WIDTH-1:0] win;
  int                    idx;
  logic                  beat, pkt_end;
  logic [WEIGHT_W-1:0]   cur_weight;
  logic [WEIGHT_W:0]     eff_weight, cnt_inc;

  // First requester scanning cyclically from the pointer.
  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    idx   = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PORT_WIDTH'(idx);
      end
    end
  end

  assign grant_valid = (state_reg == LOCKED);
  assign beat        = grant_valid & req[grant_id_reg] & out_ready;
  assign pkt_end     = beat & last[grant_id_reg];
  assign cur_weight  = weight[grant_id_reg*WEIGHT_W +: WEIGHT_W];
  assign eff_weight  = (cur_weight == '0) ? (WEIGHT_W+1)'(1) : {1'b0, cur_weight};
  assign cnt_inc     = {1'b0, cnt_reg} + (WEIGHT_W+1)'(1);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    grant_next    = grant_reg;
    grant_id_next = grant_id_reg;
    case (state_reg)
      IDLE: begin
        grant_next = '0;
        if (found) begin
          grant_next[win] = 1'b1;
          grant_id_next   = win;
          state_next      = LOCKED;
          if (win != ptr_reg) cnt_next = '0;
        end
      end
      LOCKED: begin
        if (pkt_end) begin
          state_next = IDLE;
          grant_next = '0;
          // Quota used up: rotate past the winner, otherwise let it go again.
          if (cnt_inc >= eff_weight) begin
            ptr_next = (grant_id_reg == PORT_WIDTH'(NUM_PORTS-1)) ? '0
                                                                   : grant_id_reg + PORT_WIDTH'(1);
            cnt_next = '0;
          end else begin
            ptr_next = grant_id_reg;
            cnt_next = cnt_reg + WEIGHT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      grant_reg    <= '0;
      grant_id_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      grant_reg    <= grant_next;
      grant_id_reg <= grant_id_next;
    end
  end

  assign grant     = grant_reg;
  assign grant_id  = grant_id_reg;
  assign out_valid = grant_valid & req[grant_id_reg];
  assign in_ready  = grant_reg & {NUM_PORTS{out_ready}};

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Scoreboard bench for wrr_packet_arbiter: a 4-port and a 3-port instance share clock,
// reset and out_ready; expected winners are queued per scenario and popped at each grant.
module tb_wrr_packet_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0, last = '0;
  logic [15:0] weight = 16'h1111;
  logic        out_ready = 1'b1;
  logic        out_valid, grant_valid;
  logic [3:0]  in_ready, grant;
  logic [1:0]  grant_id;

  logic [2:0]  req3 = '0;
  logic [2:0]  last3 = 3'b111;
  logic [11:0] weight3 = 12'h111;
  logic        out_valid3, grant_valid3;
  logic [2:0]  in_ready3, grant3;
  logic [1:0]  grant_id3;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  logic sel = 1'b0;
  int exp_q[$];

  logic [3:0] mon_grant, mon_ir;
  logic [1:0] mon_id;
  logic       mon_gv, mon_ov;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  wrr_packet_arbiter #(.NUM_PORTS(4), .WEIGHT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last), .weight(weight),
    .out_ready(out_ready), .out_valid(out_valid), .in_ready(in_ready),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid)
  );

  wrr_packet_arbiter #(.NUM_PORTS(3), .WEIGHT_W(4)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .last(last3), .weight(weight3),
    .out_ready(out_ready), .out_valid(out_valid3), .in_ready(in_ready3),
    .grant(grant3), .grant_id(grant_id3), .grant_valid(grant_valid3)
  );

  always_comb begin
    mon_grant = sel ? {1'b0, grant3}    : grant;
    mon_ir    = sel ? {1'b0, in_ready3} : in_ready;
    mon_id    = sel ? grant_id3         : grant_id;
    mon_gv    = sel ? grant_valid3      : grant_valid;
    mon_ov    = sel ? out_valid3        : out_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic reset_on();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_grant", {28'd0, mon_grant}, 32'd0);
    check("rst_gv", {31'd0, mon_gv}, 32'd0);
    check("rst_id", {30'd0, mon_id}, 32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Watch for grant starts, pop the expected winner for each, bounded by a cycle budget.
  task automatic run(input int npk, input int spacing);
    int   seen = 0;
    int   cyc = 0;
    int   last_start = -1;
    int   exp;
    logic prev = mon_gv;
    while (seen < npk && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check("gv_vs_grant", {31'd0, mon_gv}, {31'd0, |mon_grant});
      if (mon_gv && !prev) begin
        exp = exp_q.pop_front();
        $display("[TB] packet start: port %0d (expected %0d) at cycle %0d", mon_id, exp, cycle);
        check("grant_id", {30'd0, mon_id}, exp);
        check("grant_onehot", {28'd0, mon_grant}, 32'd1 << exp);
        if (spacing != 0 && last_start >= 0) check("spacing", cyc - last_start, spacing);
        last_start = cyc;
        seen++;
      end
      prev = mon_gv;
    end
    if (seen < npk) check("timeout", seen, npk);
  endtask

  int   rdy_pat[6] = '{1, 1, 0, 0, 1, 1};
  int   lst_pat[6] = '{0, 0, 0, 0, 0, 1};

  initial begin
    // Plain round robin, single-beat packets.
    sel = 1'b0; weight = 16'h1111;
    reset_on();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    release_rst();
    foreach (rdy_pat[i]) ;
    exp_q = '{0, 1, 2, 3, 0};
    run(5, 2);

    // Weighted: port 0 weight 3.
    reset_on();
    weight = {4'd1, 4'd1, 4'd1, 4'd3};
    release_rst();
    exp_q = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
    run(9, 2);

    // Weight 0 behaves as weight 1.
    reset_on();
    weight = {4'd1, 4'd0, 4'd1, 4'd1};
    release_rst();
    exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
    run(8, 2);

    // Port 1 four-beat packet with a two-cycle stall; ports 0 and 2 contend.
    reset_on();
    weight = 16'h1111;
    req = 4'b0010; last = 4'b0000; out_ready = 1'b1;
    release_rst();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("lock_grant", {28'd0, grant}, 32'h2);
      req = 4'b0111;
      out_ready = rdy_pat[i][0];
      last = lst_pat[i][0] ? 4'b0010 : 4'b0000;
      #1;
      check("lock_in_ready", {28'd0, in_ready}, out_ready ? 32'h2 : 32'h0);
      check("lock_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    check("lock_bubble", {28'd0, grant}, 32'h0);
    last = 4'b0000; out_ready = 1'b1;
    @(negedge clk);
    $display("[TB] after locked packet: port %0d granted", grant_id);
    check("lock_next", {30'd0, grant_id}, 32'd2);

    // Three ports, port 1 idle: pointer wraps 2 -> 0.
    sel = 1'b1;
    reset_on();
    req3 = 3'b101; last3 = 3'b111; out_ready = 1'b1;
    release_rst();
    exp_q = '{0, 2, 0, 2};
    run(4, 2);

    // Reset in the middle of a port-3 packet.
    sel = 1'b0;
    reset_on();
    req = 4'b1000; last = 4'b0000; out_ready = 1'b1;
    release_rst();
    @(negedge clk);
    check("rst_mid_grant", {28'd0, grant}, 32'h8);
    @(negedge clk);
    check("rst_mid_ov", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_grant0", {28'd0, grant}, 32'd0);
    check("rst_mid_id0", {30'd0, grant_id}, 32'd0);
    check("rst_mid_gv0", {31'd0, grant_valid}, 32'd0);
    check("rst_mid_ov0", {31'd0, out_valid}, 32'd0);
    check("rst_mid_ir0", {28'd0, in_ready}, 32'd0);
    req = 4'b1111; last = 4'b1111;
    release_rst();
    exp_q = '{0};
    run(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
